// File: rtl/itch_msg_arbiter.sv
// itch_msg_arbiter
// Collects parsed ITCH messages from NUM_CH decoder channels into one
// holding register per channel, then forwards them one at a time onto a
// single valid/ready output using round-robin arbitration. A channel that
// receives a new message while its holding register is still occupied
// (and not being drained that cycle) loses the new message; such losses
// are flagged per channel and totalled in a saturating counter.
module itch_msg_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        drop_pulse,
  output logic [15:0]              drop_count
);

  localparam int CH_W = 2;

  logic [NUM_CH-1:0] hold_valid;
  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic [CH_W-1:0]   last_grant;

  logic              out_free;
  logic              grant_any;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic [NUM_CH-1:0] grant_vec;
  logic [NUM_CH-1:0] capture_vec;
  logic [NUM_CH-1:0] drop_vec;
  logic [2:0]        drop_num;
  logic [16:0]       drop_sum;

  // Round-robin search starting just after the last granted channel, plus
  // the per-channel capture/drop decisions that depend on this cycle's grant.
  always_comb begin
    out_free  = !out_valid || out_ready;
    grant_any = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!grant_any && hold_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vec   = (out_free && grant_any) ? (NUM_CH'(1) << grant_idx) : '0;
    // A channel being drained this cycle can take a new message at once.
    capture_vec = in_valid & (~hold_valid | grant_vec);
    drop_vec    = in_valid & hold_valid & ~grant_vec;
    drop_num    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_num = drop_num + 3'(drop_vec[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_num);
  end

  // Per-channel holding registers: fill on capture, empty on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture_vec[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= in_data[i*DATA_W +: DATA_W];
        end else if (grant_vec[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output register stage, arbitration pointer and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      drop_pulse <= '0;
      drop_count <= '0;
    end else begin
      if (out_free) begin
        if (grant_any) begin
          out_valid  <= 1'b1;
          out_ch     <= grant_idx;
          out_data   <= hold_data[grant_idx];
          last_grant <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
      drop_pulse <= drop_vec;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_itch_msg_arbiter.sv
// tb_itch_msg_arbiter
// Directed, table-driven bench for itch_msg_arbiter. Each table row gives
// the inputs applied before one rising edge and the outputs expected just
// after it. Payloads are tagged as {channel, tag} so the source of every
// delivered message is visible in out_data.
module tb_itch_msg_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 128;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_ch;
  logic [DATA_W-1:0]        out_data;
  logic [NUM_CH-1:0]        drop_pulse;
  logic [15:0]              drop_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0]  iv;
    int          tag;
    logic        rdy;
    logic        eov;
    logic [1:0]  ech;
    int          etag;
    logic [3:0]  edp;
    logic [15:0] edc;
  } vec_t;

  vec_t vecs[$];

  itch_msg_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch(out_ch),
    .out_data(out_data),
    .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] mk(input int ch, input int tag);
    logic [7:0]  c;
    logic [23:0] t;
    c = ch[7:0];
    t = tag[23:0];
    return {4{c, t}};
  endfunction

  task automatic addRow(input logic [3:0] iv, input int tag, input logic rdy,
                        input logic eov, input logic [1:0] ech, input int etag,
                        input logic [3:0] edp, input logic [15:0] edc);
    vec_t v;
    v.iv = iv; v.tag = tag; v.rdy = rdy;
    v.eov = eov; v.ech = ech; v.etag = etag; v.edp = edp; v.edc = edc;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then wait until just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] iv, input int tag,
                               input logic rdy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    out_ready = rdy;
    for (int i = 0; i < NUM_CH; i++) begin
      in_data[i*DATA_W +: DATA_W] = mk(i, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eov, input logic [1:0] ech,
                             input logic [DATA_W-1:0] edata, input logic [3:0] edp,
                             input logic [15:0] edc);
    tests_run++;
    if (out_valid !== eov) begin
      tests_failed++;
      $display("[TB] FAIL %s out_valid got %0b want %0b", name, out_valid, eov);
    end
    tests_run++;
    if (out_ch !== ech) begin
      tests_failed++;
      $display("[TB] FAIL %s out_ch got %0d want %0d", name, out_ch, ech);
    end
    tests_run++;
    if (out_data !== edata) begin
      tests_failed++;
      $display("[TB] FAIL %s out_data got %h want %h", name, out_data, edata);
    end
    tests_run++;
    if (drop_pulse !== edp) begin
      tests_failed++;
      $display("[TB] FAIL %s drop_pulse got %b want %b", name, drop_pulse, edp);
    end
    tests_run++;
    if (drop_count !== edc) begin
      tests_failed++;
      $display("[TB] FAIL %s drop_count got %0d want %0d", name, drop_count, edc);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = '0;
    in_data      = '0;
    out_ready    = 1'b0;

    // All four channels at once from reset: grants 0,1,2,3 back to back.
    addRow(4'b1111, 1, 1, 0, 0, 0, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 1, 0, 1, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 1, 1, 1, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 1, 2, 1, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 1, 3, 1, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 0, 3, 1, 4'b0000, 0);
    // Single pulse on channel 2: out_valid two edges later, then drops.
    addRow(4'b0100, 2, 1, 0, 3, 1, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 1, 2, 2, 4'b0000, 0);
    addRow(4'b0000, 0, 1, 0, 2, 2, 4'b0000, 0);
    // Backpressure for ten cycles: output holds ch0, ch1 second pulse lost.
    addRow(4'b0001, 3, 0, 0, 2, 2, 4'b0000, 0);
    addRow(4'b0010, 4, 0, 1, 0, 3, 4'b0000, 0);
    addRow(4'b0010, 5, 0, 1, 0, 3, 4'b0010, 1);
    for (int k = 0; k < 7; k++) begin
      addRow(4'b0000, 0, 0, 1, 0, 3, 4'b0000, 1);
    end
    addRow(4'b0000, 0, 1, 1, 1, 4, 4'b0000, 1);
    addRow(4'b0000, 0, 1, 0, 1, 4, 4'b0000, 1);
    // Channels 0 and 3 pulsing every cycle: grants alternate, one drop each cycle.
    addRow(4'b1001, 6, 1, 0, 1, 4, 4'b0000, 1);
    addRow(4'b1001, 7, 1, 1, 3, 6, 4'b0001, 2);
    addRow(4'b1001, 8, 1, 1, 0, 6, 4'b1000, 3);
    addRow(4'b1001, 9, 1, 1, 3, 7, 4'b0001, 4);
    addRow(4'b0000, 0, 1, 1, 0, 8, 4'b0000, 4);
    addRow(4'b0000, 0, 1, 1, 3, 9, 4'b0000, 4);
    addRow(4'b0000, 0, 1, 0, 3, 9, 4'b0000, 4);

    // Reset state, with in_valid asserted during reset.
    applyStimulus(1, 4'b1111, 0, 1);
    checkOutput("reset", 0, 0, '0, 4'b0000, 0);

    foreach (vecs[n]) begin
      applyStimulus(0, vecs[n].iv, vecs[n].tag, vecs[n].rdy);
      checkOutput($sformatf("row%0d", n), vecs[n].eov, vecs[n].ech,
                  mk(vecs[n].ech, vecs[n].etag), vecs[n].edp, vecs[n].edc);
    end

    // Reset mid-traffic with output busy and every holding register full.
    applyStimulus(0, 4'b1111, 10, 0);
    checkOutput("mid_fill", 0, 3, mk(3, 9), 4'b0000, 4);
    applyStimulus(0, 4'b0000, 0, 0);
    checkOutput("mid_grant", 1, 0, mk(0, 10), 4'b0000, 4);
    applyStimulus(0, 4'b0001, 11, 0);
    checkOutput("mid_refill", 1, 0, mk(0, 10), 4'b0000, 4);
    applyStimulus(1, 4'b1111, 12, 0);
    checkOutput("mid_rst", 0, 0, '0, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0, 1);
    checkOutput("post_rst_idle", 0, 0, '0, 4'b0000, 0);
    applyStimulus(0, 4'b1001, 13, 1);
    checkOutput("post_rst_accept", 0, 0, '0, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0, 1);
    checkOutput("post_rst_g0", 1, 0, mk(0, 13), 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0, 1);
    checkOutput("post_rst_g3", 1, 3, mk(3, 13), 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0, 1);
    checkOutput("post_rst_end", 0, 3, mk(3, 13), 4'b0000, 0);

    // Drop counter saturation: all channels pulse with output stalled.
    applyStimulus(1, 4'b0000, 0, 0);
    checkOutput("sat_rst", 0, 0, '0, 4'b0000, 0);
    for (int n = 1; n <= 17600; n++) begin
      applyStimulus(0, 4'b1111, 8'h55, 0);
      if (n == 2) begin
        checkOutput("sat_first", 1, 0, mk(0, 8'h55), 4'b1110, 3);
      end
      if (n == 100) begin
        checkOutput("sat_mid", 1, 0, mk(0, 8'h55), 4'b1111, 395);
      end
      if (n == 16385) begin
        checkOutput("sat_near", 1, 0, mk(0, 8'h55), 4'b1111, 16'hFFFF);
      end
    end
    checkOutput("sat_full", 1, 0, mk(0, 8'h55), 4'b1111, 16'hFFFF);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(0, 4'b1111, 8'h55, 0);
      checkOutput($sformatf("sat_hold%0d", n), 1, 0, mk(0, 8'h55), 4'b1111, 16'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
